// File: rtl/sevseg_pkg.sv
// sevseg_pkg
//   Shared widths, the stock digit patterns and the power-up frame table for
//   the seven-segment frame player. Segment bit order is {dp,g,f,e,d,c,b,a}.
package sevseg_pkg;

    localparam int SEG_W       = 8;
    localparam int ADDR_W      = 3;
    localparam int SER_FRAME_W = ADDR_W + SEG_W;   // {addr[2:0], pattern[7:0]}
    localparam int TABLE_N     = 1 << ADDR_W;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam seg_t SEG_DIGIT_0 = 8'h3F;
    localparam seg_t SEG_DIGIT_1 = 8'h06;
    localparam seg_t SEG_DIGIT_2 = 8'h5B;
    localparam seg_t SEG_DIGIT_3 = 8'h4F;
    localparam seg_t SEG_DIGIT_4 = 8'h66;
    localparam seg_t SEG_DIGIT_5 = 8'h6D;
    localparam seg_t SEG_DIGIT_6 = 8'h7D;
    localparam seg_t SEG_DIGIT_7 = 8'h07;

    // Entry i sits at slice [i]; the table powers up showing digits 0..7.
    localparam logic [TABLE_N-1:0][SEG_W-1:0] DEFAULT_TABLE = {
        SEG_DIGIT_7, SEG_DIGIT_6, SEG_DIGIT_5, SEG_DIGIT_4,
        SEG_DIGIT_3, SEG_DIGIT_2, SEG_DIGIT_1, SEG_DIGIT_0
    };

endpackage

// File: rtl/sevseg_frame_player_if.sv
// sevseg_frame_player_if
//   Bundles the step input, the three-wire serial load pins and the display /
//   status outputs of the frame player.
//   master : drives i_count and the serial pins, observes the outputs
//   slave  : the frame player itself
interface sevseg_frame_player_if;
    import sevseg_pkg::*;

    addr_t i_count;         // step index, synchronous to the system clock
    logic  i_ser_clk;       // serial load clock (asynchronous pin)
    logic  i_ser_data;      // serial load data, MSB first (asynchronous pin)
    logic  i_ser_latch;     // serial commit (asynchronous pin)
    seg_t  o_seg;           // registered segment drive {dp,g,f,e,d,c,b,a}
    logic  o_frame_strobe;  // one-cycle pulse when o_seg moves to a new step
    logic  o_load_done;     // one-cycle pulse on a table write
    logic  o_load_err;      // one-cycle pulse on a short frame at latch

    modport master (
        output i_count, i_ser_clk, i_ser_data, i_ser_latch,
        input  o_seg, o_frame_strobe, o_load_done, o_load_err
    );

    modport slave (
        input  i_count, i_ser_clk, i_ser_data, i_ser_latch,
        output o_seg, o_frame_strobe, o_load_done, o_load_err
    );

endinterface

// File: rtl/sevseg_sync_edge.sv
// sevseg_sync_edge
//   Brings one asynchronous pin into the clk domain through SYNC_STAGES flops
//   and, when EDGE_EN is set, flags its rising edge with a one-cycle pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears the chain
//   pin   : asynchronous input
//   level : synchronized level
//   rise  : one-cycle pulse on a synchronized 0->1 transition (0 if EDGE_EN=0)
module sevseg_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
        end
    end

    assign level = chain[SYNC_STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic prev;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev <= 1'b0;
            end else begin
                prev <= level;
            end
        end

        assign rise = level & ~prev;
    end else begin : g_no_edge
        assign rise = 1'b0;
    end

endmodule

// File: rtl/sevseg_frame_player.sv
// sevseg_frame_player
//   Shows table[i_count] on a seven-segment display and strobes once per step
//   change. The 8-entry pattern table can be rewritten at run time by an
//   11-bit serial frame {addr, pattern} shifted in on slow asynchronous pins.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset (table back to digits 0..7)
//   bus    : slave side of sevseg_frame_player_if (step input, serial pins,
//            o_seg / o_frame_strobe / o_load_done / o_load_err)
//   SYNC_STAGES : synchronizer depth on each serial pin (>= 2)
//   INVERT_OUT  : 1 inverts o_seg for common-anode displays
module sevseg_frame_player
    import sevseg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit INVERT_OUT  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sevseg_frame_player_if.slave  bus
);

    localparam seg_t OUT_MASK = INVERT_OUT ? '1 : '0;
    localparam int   CNT_W    = $clog2(SER_FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SER_FRAME_W);

    logic ser_clk_rise, ser_latch_rise, ser_data_lvl;
    logic ser_clk_lvl_unused, ser_latch_lvl_unused, ser_data_rise_unused;

    sevseg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_clk (
        .clk(i_clk), .rst(i_rst), .pin(bus.i_ser_clk),
        .level(ser_clk_lvl_unused), .rise(ser_clk_rise)
    );

    sevseg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_latch (
        .clk(i_clk), .rst(i_rst), .pin(bus.i_ser_latch),
        .level(ser_latch_lvl_unused), .rise(ser_latch_rise)
    );

    sevseg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_data (
        .clk(i_clk), .rst(i_rst), .pin(bus.i_ser_data),
        .level(ser_data_lvl), .rise(ser_data_rise_unused)
    );

    logic [TABLE_N-1:0][SEG_W-1:0] table_q;
    logic [SER_FRAME_W-1:0]        sh_q, sh_next;
    logic [CNT_W-1:0]              bits_q, bits_next;
    addr_t                         count_q;
    seg_t                          seg_q;
    logic                          strobe_q, done_q, err_q;

    logic  commit, step;
    addr_t wr_addr;
    seg_t  wr_seg, step_seg;

    // The shift happens before the commit is judged, so a latch edge that
    // coincides with the last clock edge still sees the complete frame.
    always_comb begin
        sh_next   = sh_q;
        bits_next = bits_q;
        if (ser_clk_rise) begin
            sh_next = {sh_q[SER_FRAME_W-2:0], ser_data_lvl};
            if (bits_q != FULL) begin
                bits_next = bits_q + CNT_W'(1);
            end
        end
    end

    assign commit  = ser_latch_rise && (bits_next == FULL);
    assign wr_addr = sh_next[SER_FRAME_W-1 -: ADDR_W];
    assign wr_seg  = sh_next[SEG_W-1:0];
    assign step    = (bus.i_count != count_q);

    // Write-first: a step onto the entry being written shows the new pattern.
    assign step_seg = (commit && (wr_addr == bus.i_count)) ? wr_seg
                                                           : table_q[bus.i_count];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            table_q  <= DEFAULT_TABLE;
            sh_q     <= '0;
            bits_q   <= '0;
            count_q  <= '0;
            seg_q    <= DEFAULT_TABLE[0] ^ OUT_MASK;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sh_q     <= sh_next;
            bits_q   <= ser_latch_rise ? '0 : bits_next;
            count_q  <= bus.i_count;
            strobe_q <= step;
            done_q   <= commit;
            err_q    <= ser_latch_rise & ~commit;
            if (commit) begin
                table_q[wr_addr] <= wr_seg;
            end
            // Without a step the display keeps tracking the current entry,
            // which brings a rewrite of that entry out one edge after commit.
            if (step) begin
                seg_q <= step_seg ^ OUT_MASK;
            end else begin
                seg_q <= table_q[count_q] ^ OUT_MASK;
            end
        end
    end

    assign bus.o_seg          = seg_q;
    assign bus.o_frame_strobe = strobe_q;
    assign bus.o_load_done    = done_q;
    assign bus.o_load_err     = err_q;

endmodule

// File: tb/tb_sevseg_frame_player.sv
// tb_sevseg_frame_player
//   Drives two frame players (normal and inverted output) from the same
//   stimulus and compares both against a sample-history reference model,
//   plus table-driven and hand-written sequences with fixed expectations.
module tb_sevseg_frame_player;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cnt = 3'd0;
    logic       sclk = 1'b0, sdat = 1'b0, slat = 1'b0;
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    sevseg_frame_player_if bus0();
    sevseg_frame_player_if bus1();

    assign bus0.i_count = cnt;   assign bus1.i_count = cnt;
    assign bus0.i_ser_clk = sclk; assign bus1.i_ser_clk = sclk;
    assign bus0.i_ser_data = sdat; assign bus1.i_ser_data = sdat;
    assign bus0.i_ser_latch = slat; assign bus1.i_ser_latch = slat;

    sevseg_frame_player #(.SYNC_STAGES(S), .INVERT_OUT(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0)
    );
    sevseg_frame_player #(.SYNC_STAGES(S), .INVERT_OUT(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1)
    );

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] def_pat(int i);
        case (i)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; default: return 8'h07;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Pin samples are kept newest-first; an action at an edge is decided by
    // the samples taken S and S+1 edges earlier.
    logic [7:0] m_tab [8];
    logic [2:0] m_cnt_q;
    logic [7:0] m_seg;
    bit         m_strobe, m_done, m_err, m_live;
    bit         hc[$], hd[$], hl[$];
    bit         mbits[$];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_tab[i] = def_pat(i);
        m_cnt_q = 3'd0; m_seg = 8'h3F;
        m_strobe = 0; m_done = 0; m_err = 0; m_live = 0;
        hc.delete(); hd.delete(); hl.delete(); mbits.delete();
        for (int i = 0; i < S + 2; i++) begin
            hc.push_back(1'b0); hd.push_back(1'b0); hl.push_back(1'b0);
        end
    endfunction

    function automatic void model_step();
        bit crise, lrise, d, wrote;
        logic [10:0] f;
        logic [7:0] shown;
        logic [2:0] wa;
        hc.push_front(sclk); hd.push_front(sdat); hl.push_front(slat);
        void'(hc.pop_back()); void'(hd.pop_back()); void'(hl.pop_back());
        crise = hc[S] && !hc[S+1];
        lrise = hl[S] && !hl[S+1];
        d     = hd[S];
        m_strobe = 0; m_done = 0; m_err = 0; wrote = 0; wa = 3'd0;
        shown = m_tab[m_cnt_q];
        if (crise) begin
            mbits.push_back(d);
            if (mbits.size() > 11) void'(mbits.pop_front());
        end
        if (lrise) begin
            if (mbits.size() == 11) begin
                f = 11'd0;
                for (int i = 0; i < 11; i++) f = f * 2 + 11'(mbits[i]);
                wa = f[10:8];
                m_tab[wa] = f[7:0];
                wrote = 1; m_done = 1;
            end else begin
                m_err = 1;
            end
            mbits.delete();
        end
        if (cnt != m_cnt_q) begin
            m_seg = m_tab[cnt]; m_strobe = 1;
        end else if (m_live) begin
            m_seg = shown;
        end
        m_live  = wrote && (wa == m_cnt_q) && (cnt == m_cnt_q);
        m_cnt_q = cnt;
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg_n", bus0.o_seg, m_seg);
            check("model_seg_i", bus1.o_seg, ~m_seg);
            check("model_strobe_n", 8'(bus0.o_frame_strobe), 8'(m_strobe));
            check("model_strobe_i", 8'(bus1.o_frame_strobe), 8'(m_strobe));
            check("model_done_n", 8'(bus0.o_load_done), 8'(m_done));
            check("model_done_i", 8'(bus1.o_load_done), 8'(m_done));
            check("model_err_n", 8'(bus0.o_load_err), 8'(m_err));
            check("model_err_i", 8'(bus1.o_load_err), 8'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_seg(string name, logic [7:0] exp);
        check({name, "_n"}, bus0.o_seg, exp);
        check({name, "_i"}, bus1.o_seg, ~exp);
    endtask

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdat = v[i]; sclk = 1'b0; tick();
            sclk = 1'b1; tick();
        end
        sclk = 1'b0; tick();
    endtask

    task automatic latch_frame(output int nd, output int ne);
        nd = 0; ne = 0;
        slat = 1'b1;
        for (int i = 0; i < S + 4; i++) begin
            tick();
            if (i == 1) slat = 1'b0;
            nd += int'(bus0.o_load_done) + int'(bus1.o_load_done);
            ne += int'(bus0.o_load_err) + int'(bus1.o_load_err);
        end
    endtask

    typedef struct {
        logic [2:0] cnt;
        logic [7:0] seg;
        logic       strobe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int nd, ne, nstrobe;
        vecs[0] = '{3'd0, 8'h3F, 1'b0};
        vecs[1] = '{3'd1, 8'h06, 1'b1};
        vecs[2] = '{3'd2, 8'h5B, 1'b1};
        vecs[3] = '{3'd3, 8'h4F, 1'b1};
        vecs[4] = '{3'd4, 8'h66, 1'b1};
        vecs[5] = '{3'd5, 8'h6D, 1'b1};
        vecs[6] = '{3'd6, 8'h7D, 1'b1};
        vecs[7] = '{3'd7, 8'h07, 1'b1};
        vecs[8] = '{3'd0, 8'h3F, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk_seg("reset_seg", 8'h3F);
        check("reset_strobe", 8'(bus0.o_frame_strobe), 8'd0);

        // Test 1: table-driven step walk including the 7->0 wrap
        nstrobe = 0;
        foreach (vecs[k]) begin
            cnt = vecs[k].cnt;
            tick();
            chk_seg($sformatf("walk%0d_seg", k), vecs[k].seg);
            check($sformatf("walk%0d_strobe", k), 8'(bus0.o_frame_strobe), 8'(vecs[k].strobe));
            nstrobe += int'(bus0.o_frame_strobe);
        end
        check("walk_strobe_count", 8'(nstrobe), 8'd8);

        // Test 2: load addr 5 = 0x80, then show it
        shift_bits(16'b101_10000000, 11);
        latch_frame(nd, ne);
        check("load5_done", 8'(nd), 8'd2);
        check("load5_err", 8'(ne), 8'd0);
        cnt = 3'd5; tick();
        chk_seg("show5", 8'h80);

        // Test 3: live rewrite of the displayed entry
        cnt = 3'd2; tick(); tick();
        shift_bits(16'b010_01001001, 11);
        slat = 1'b1;
        repeat (S + 1) tick();
        check("live_done", 8'(bus0.o_load_done), 8'd1);
        chk_seg("live_before", 8'h5B);
        tick();
        chk_seg("live_after", 8'h49);
        check("live_no_strobe", 8'(bus0.o_frame_strobe), 8'd0);
        slat = 1'b0; repeat (3) tick();

        // Test 4: short frame rejected, then an over-long frame keeps its last 11 bits
        shift_bits(16'b1010101, 7);
        latch_frame(nd, ne);
        check("short_done", 8'(nd), 8'd0);
        check("short_err", 8'(ne), 8'd2);
        chk_seg("short_keep", 8'h49);
        cnt = 3'd5; tick();
        chk_seg("short_tab5", 8'h80);
        shift_bits(16'b11_110_01011010, 13);
        latch_frame(nd, ne);
        check("long_done", 8'(nd), 8'd2);
        cnt = 3'd6; tick();
        chk_seg("long_tab6", 8'h5A);

        // Test 5: commit to addr 3 on the same edge the step goes 2->3
        cnt = 3'd2; tick(); tick();
        shift_bits(16'b011_01110111, 11);
        slat = 1'b1;
        repeat (S) tick();
        cnt = 3'd3;
        tick();
        chk_seg("bypass_seg", 8'h77);
        check("bypass_strobe", 8'(bus0.o_frame_strobe), 8'd1);
        check("bypass_done", 8'(bus0.o_load_done), 8'd1);
        slat = 1'b0; repeat (3) tick();

        // Test 6: reset in the middle of a load
        shift_bits(16'b001_00010001, 11);
        latch_frame(nd, ne);
        cnt = 3'd1; tick();
        chk_seg("mod1_seg", 8'h11);
        for (int i = 0; i < 6; i++) begin
            sdat = i[0]; sclk = 1'b0; tick();
            sclk = 1'b1; tick();
        end
        rst = 1'b1;
        model_reset();
        #1;
        chk_seg("rst_immediate", 8'h3F);
        sclk = 1'b0; sdat = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_seg("rst_default1", 8'h06);
        check("rst_step_strobe", 8'(bus0.o_frame_strobe), 8'd1);
        shift_bits(16'b100_00111100, 11);
        latch_frame(nd, ne);
        check("fresh_done", 8'(nd), 8'd2);
        cnt = 3'd4; tick();
        chk_seg("fresh_tab4", 8'h3C);

        // Randomized pins and steps against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) cnt = 3'($urandom_range(0, 7));
            sdat = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) sclk = ~sclk;
            if ($urandom_range(0, 29) == 0) slat = ~slat;
            tick();
        end
        repeat (S + 4) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
